// File: rtl/expo_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | expo_arbiter                                                               |
// | Round-robin front end sharing one a^b engine, with a single-entry result   |
// | cache, trivial-exponent bypass and hung-engine timeout recovery.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module expo_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err,
    output logic                 rsp_cached,
    output logic [7:0]           eng_a,
    output logic [7:0]           eng_b,
    input  logic [31:0]          eng_out,
    input  logic                 eng_ready,
    output logic                 eng_clr_n
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        BUSY   = 3'd2,
        CLEAR  = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [PTR_W-1:0]   r_rr_ptr;
    logic [TMR_W-1:0]   r_timer;
    logic [7:0]         r_key_a;
    logic [7:0]         r_key_b;
    logic [31:0]        r_key_data;

    logic               w_found;
    logic [PTR_W-1:0]   w_gnt_idx;
    logic [7:0]         w_sel_a;
    logic [7:0]         w_sel_b;
    logic               w_trivial;
    logic               w_hit;
    logic               w_timeout;
    logic               w_grant;
    logic               w_launch;
    logic               w_done;

    // First pending requester at or after the round-robin pointer.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                w_found   = 1'b1;
                w_gnt_idx = PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign w_sel_a   = req_a[8*w_gnt_idx +: 8];
    assign w_sel_b   = req_b[8*w_gnt_idx +: 8];
    assign w_trivial = (w_sel_b == 8'd0);
    assign w_hit     = ({w_sel_a, w_sel_b} == {r_key_a, r_key_b});
    assign w_timeout = (r_timer == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_launch     = 1'b0;
        w_done       = 1'b0;
        req_ready    = '0;
        case (r_state)
            IDLE: begin
                if (w_found && !reset) begin
                    w_grant              = 1'b1;
                    req_ready[w_gnt_idx] = 1'b1;
                    if (w_trivial || w_hit) begin
                        w_state_next = RESP;
                    end else begin
                        w_launch     = 1'b1;
                        w_state_next = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                if (!eng_ready) begin
                    w_state_next = BUSY;
                end else if (w_timeout) begin
                    w_state_next = CLEAR;
                end
            end
            BUSY: begin
                if (eng_ready) begin
                    w_done       = 1'b1;
                    w_state_next = RESP;
                end else if (w_timeout) begin
                    w_state_next = CLEAR;
                end
            end
            CLEAR: begin
                w_state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign rsp_valid = (r_state == RESP);
    assign eng_clr_n = (r_state != CLEAR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr   <= '0;
            r_timer    <= '0;
            r_key_a    <= 8'd0;
            r_key_b    <= 8'd0;
            r_key_data <= 32'd1;
            rsp_id     <= '0;
            rsp_data   <= 32'd0;
            rsp_err    <= 1'b0;
            rsp_cached <= 1'b0;
            eng_a      <= 8'd0;
            eng_b      <= 8'd0;
        end else begin
            if (w_grant) begin
                r_rr_ptr   <= PTR_W'((int'(w_gnt_idx) + 1) % NUM_REQ);
                rsp_id     <= ID_W'(w_gnt_idx);
                rsp_err    <= 1'b0;
                rsp_cached <= w_trivial || w_hit;
                rsp_data   <= w_trivial ? 32'd1 : r_key_data;
            end
            if (w_launch) begin
                eng_a   <= w_sel_a;
                eng_b   <= w_sel_b;
                r_timer <= '0;
            end else if (r_state == LAUNCH || r_state == BUSY) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_done) begin
                rsp_data   <= eng_out;
                r_key_a    <= eng_a;
                r_key_b    <= eng_b;
                r_key_data <= eng_out;
            end
            // A cleared engine holds pair {0,0}; 0^0 is taken as 1.
            if (r_state == CLEAR) begin
                eng_a      <= 8'd0;
                eng_b      <= 8'd0;
                r_key_a    <= 8'd0;
                r_key_b    <= 8'd0;
                r_key_data <= 32'd1;
                rsp_err    <= 1'b1;
                rsp_data   <= 32'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/expo_arbiter.md
Name: expo_arbiter

Overview:
- Shares one 8-bit base / 8-bit exponent / 32-bit result exponentiation engine among NUM_REQ requesters using round-robin arbitration.
- Drives the engine's operand inputs and tracks its ready flag through each operation.
- Returns tagged results on a single response channel with valid/ready backpressure.
- Serves trivial and repeated requests without launching the engine, and recovers a hung engine by timeout.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 64, cycles allowed per engine operation before abort.
- ID_W, 2, width of rsp_id; must be at least ceil(log2(NUM_REQ)).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request pending
- req_a  in  8*NUM_REQ  packed bases; requester i at bits [8i+7:8i]
- req_b  in  8*NUM_REQ  packed exponents; same packing as req_a
- req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  ID_W  index of the requester being answered
- rsp_data  out  32  a^b mod 2^32
- rsp_err  out  1  engine timed out; rsp_data=0
- rsp_cached  out  1  result produced without an engine launch
- eng_a  out  8  engine base; held stable between launches
- eng_b  out  8  engine exponent; held stable between launches
- eng_out  in  32  engine result
- eng_ready  in  1  engine idle flag
- eng_clr_n  out  1  active-low engine clear; 1 except during CLEAR

Behaviour:
- Reset values: all outputs 0 except eng_clr_n=1. rr_ptr=0; state=IDLE; cache key={0,0}, cache data=1.
- Engine contract: the engine starts only when eng_ready=1 and {eng_a,eng_b} differ from its previously captured pair. It drops eng_ready on the edge after it captures the new pair and raises it when done. eng_out is valid while eng_ready=1 after completion.
- States and transitions:
  - IDLE: if any req_valid, grant the first requester at or after rr_ptr (cyclic). Assert its req_ready for exactly 1 cycle, latch a, b and id, set rr_ptr=id+1 (wraps to 0). Then branch:
    - b==0: rsp_data=1, rsp_cached=1, go to RESP.
    - {a,b}==cache key: rsp_data=cache data, rsp_cached=1, go to RESP.
    - otherwise: drive eng_a/eng_b with the latched pair, clear the timer, go to LAUNCH.
  - LAUNCH: wait for eng_ready==0, then go to BUSY.
  - BUSY: wait for eng_ready==1. On that cycle capture rsp_data=eng_out, update cache={a,b,eng_out}, go to RESP.
  - LAUNCH and BUSY share one timer counting from LAUNCH entry. When the timer reaches TIMEOUT: go to CLEAR.
  - CLEAR: hold eng_clr_n=0 for 1 cycle. Set eng_a=eng_b=0 and cache={0,0,1}, because the engine's internal state is now 0. Then go to RESP with rsp_err=1, rsp_data=0.
  - RESP: rsp_valid=1 with rsp_id, rsp_data, rsp_err and rsp_cached stable. When rsp_valid && rsp_ready, go to IDLE.
- Latency:
  - Cached or trivial request: rsp_valid rises 1 cycle after the req_ready pulse.
  - Engine request: rsp_valid rises 1 cycle after eng_ready returns high.
- Only one operation is in flight at a time. req_valid is ignored outside IDLE, and req_ready stays 0 outside the grant cycle.
- A requester must hold req_a/req_b stable while req_valid=1. Dropping req_valid before the grant cancels the request with no side effects.
- Simultaneous requests: strict round-robin, so no requester waits more than NUM_REQ-1 grants.
- Overflow: results wrap mod 2^32 as produced by the engine; no flag is raised.
- Reset mid-operation: returns immediately to reset values and drops rsp_valid. eng_clr_n is not pulsed; the system reset also clears the engine.
- rsp_ready held low: the response is held indefinitely, the timer is idle, and no new grant is made.

Test Plan:
- Req0 a=3,b=5 with the engine model -> eng_a=3, eng_b=5; LAUNCH->BUSY; rsp_id=0, rsp_data=243, rsp_err=0, rsp_cached=0.
- Req1 (2,10) and req3 (5,3) asserted in the same cycle, rr_ptr=0 -> req1 granted first (1024), then req3 (125); rr_ptr ends at 0.
- Req2 (2,10) immediately after req1 (2,10) -> rsp_cached=1, rsp_data=1024 one cycle after grant; eng_a/eng_b unchanged; no engine launch.
- Req0 (7,0) -> rsp_data=1, rsp_cached=1; engine untouched.
- Engine model holds eng_ready=1 and never starts -> after 64 cycles eng_clr_n pulses low for 1 cycle; rsp_err=1, rsp_data=0; next (3,5) request launches normally.
- Assert reset during BUSY, then hold rsp_ready=0 on a later response -> outputs return to reset values at once; the later response holds stable for 20 cycles and no other req_ready pulses occur.
